// File: rtl/rv32i_controller.sv
// rv32i_controller: main control unit of the RV32I core.
// Combinational decode of opcode/funct3/funct7 feeding a single output
// register stage. Illegal encodings become a NOP with only illegal set.
module rv32i_controller #(
   parameter int REG_DATA_WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic [1:0] a_sel,
   output logic [2:0] imm_sel,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic [1:0] wb_sel,
   output logic       branch,
   output logic       jump,
   output logic       illegal
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [1:0] alu_op_next;
   logic       alu_src_next;
   logic [1:0] a_sel_next;
   logic [2:0] imm_sel_next;
   logic       reg_write_next;
   logic       mem_read_next;
   logic       mem_write_next;
   logic [1:0] wb_sel_next;
   logic       branch_next;
   logic       jump_next;
   logic       illegal_next;

   // Decode the current instruction fields into next-cycle control values.
   always_comb begin
      alu_op_next    = 2'b00;
      alu_src_next   = 1'b0;
      a_sel_next     = 2'b00;
      imm_sel_next   = 3'b000;
      reg_write_next = 1'b0;
      mem_read_next  = 1'b0;
      mem_write_next = 1'b0;
      wb_sel_next    = 2'b00;
      branch_next    = 1'b0;
      jump_next      = 1'b0;
      illegal_next   = 1'b0;

      case (opcode)
         OP_R: begin
            alu_op_next    = 2'b10;
            reg_write_next = 1'b1;
            // The alternate funct7 only exists for SUB and SRA.
            if (!((funct7 == F7_BASE) ||
                  (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))))
               illegal_next = 1'b1;
         end
         OP_IMM: begin
            alu_op_next    = 2'b11;
            alu_src_next   = 1'b1;
            imm_sel_next   = 3'b000;
            reg_write_next = 1'b1;
            // Shift-immediates reuse funct7 as the upper shamt field.
            if (funct3 == 3'b001 && funct7 != F7_BASE)
               illegal_next = 1'b1;
            if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
               illegal_next = 1'b1;
         end
         OP_LOAD: begin
            alu_src_next   = 1'b1;
            imm_sel_next   = 3'b000;
            mem_read_next  = 1'b1;
            reg_write_next = 1'b1;
            wb_sel_next    = 2'b01;
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
               illegal_next = 1'b1;
         end
         OP_STORE: begin
            alu_src_next   = 1'b1;
            imm_sel_next   = 3'b001;
            mem_write_next = 1'b1;
            if (funct3 > 3'b010)
               illegal_next = 1'b1;
         end
         OP_BRANCH: begin
            alu_op_next  = 2'b01;
            imm_sel_next = 3'b010;
            branch_next  = 1'b1;
            if (funct3 == 3'b010 || funct3 == 3'b011)
               illegal_next = 1'b1;
         end
         OP_JAL: begin
            a_sel_next     = 2'b01;
            alu_src_next   = 1'b1;
            imm_sel_next   = 3'b100;
            jump_next      = 1'b1;
            reg_write_next = 1'b1;
            wb_sel_next    = 2'b10;
         end
         OP_JALR: begin
            alu_src_next   = 1'b1;
            imm_sel_next   = 3'b000;
            jump_next      = 1'b1;
            reg_write_next = 1'b1;
            wb_sel_next    = 2'b10;
            if (funct3 != 3'b000)
               illegal_next = 1'b1;
         end
         OP_LUI: begin
            a_sel_next     = 2'b10;
            alu_src_next   = 1'b1;
            imm_sel_next   = 3'b011;
            reg_write_next = 1'b1;
         end
         OP_AUIPC: begin
            a_sel_next     = 2'b01;
            alu_src_next   = 1'b1;
            imm_sel_next   = 3'b011;
            reg_write_next = 1'b1;
         end
         default: illegal_next = 1'b1;
      endcase

      // An illegal instruction must not disturb any architectural state.
      if (illegal_next) begin
         alu_op_next    = 2'b00;
         alu_src_next   = 1'b0;
         a_sel_next     = 2'b00;
         imm_sel_next   = 3'b000;
         reg_write_next = 1'b0;
         mem_read_next  = 1'b0;
         mem_write_next = 1'b0;
         wb_sel_next    = 2'b00;
         branch_next    = 1'b0;
         jump_next      = 1'b0;
      end
   end

   // Output register stage; the datapath width does not affect decode, so
   // the parameter only gates elaboration of this block.
   if (REG_DATA_WIDTH > 0) begin : g_out_reg
      // Register decoded controls; async reset clears every output at once.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            alu_op    <= 2'b00;
            alu_src   <= 1'b0;
            a_sel     <= 2'b00;
            imm_sel   <= 3'b000;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            wb_sel    <= 2'b00;
            branch    <= 1'b0;
            jump      <= 1'b0;
            illegal   <= 1'b0;
         end else begin
            alu_op    <= alu_op_next;
            alu_src   <= alu_src_next;
            a_sel     <= a_sel_next;
            imm_sel   <= imm_sel_next;
            reg_write <= reg_write_next;
            mem_read  <= mem_read_next;
            mem_write <= mem_write_next;
            wb_sel    <= wb_sel_next;
            branch    <= branch_next;
            jump      <= jump_next;
            illegal   <= illegal_next;
         end
      end
   end

endmodule

// File: tb/tb_rv32i_controller.sv
// tb_rv32i_controller: directed decode vectors for rv32i_controller.
// Outputs are packed as {alu_op, alu_src, a_sel, imm_sel, reg_write,
// mem_read, mem_write, wb_sel, branch, jump, illegal} (16 bits).
module tb_rv32i_controller;

   logic       clk;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [1:0] alu_op;
   logic       alu_src;
   logic [1:0] a_sel;
   logic [2:0] imm_sel;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic [1:0] wb_sel;
   logic       branch;
   logic       jump;
   logic       illegal;

   int n_vec;
   int n_err;

   logic [15:0] obs;
   assign obs = {alu_op, alu_src, a_sel, imm_sel, reg_write, mem_read,
                 mem_write, wb_sel, branch, jump, illegal};

   rv32i_controller #(.REG_DATA_WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7    (funct7),
      .alu_op    (alu_op),
      .alu_src   (alu_src),
      .a_sel     (a_sel),
      .imm_sel   (imm_sel),
      .reg_write (reg_write),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .wb_sel    (wb_sel),
      .branch    (branch),
      .jump      (jump),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected-vector builder.
   function automatic logic [15:0] e(input logic [1:0] aop, input logic asrc,
                                     input logic [1:0] asel, input logic [2:0] imm,
                                     input logic rw, input logic mr, input logic mw,
                                     input logic [1:0] wb, input logic br,
                                     input logic jp, input logic ill);
      return {aop, asrc, asel, imm, rw, mr, mw, wb, br, jp, ill};
   endfunction

   task automatic check_vec(input string tag, input logic [15:0] got,
                            input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Entered at a falling edge: drive fields, wait one full cycle, compare.
   // For illegal vectors the ALU class is not compared.
   task automatic run_vec(input string tag, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7,
                          input logic [15:0] want);
      logic [15:0] mask;
      opcode = op;
      funct3 = f3;
      funct7 = f7;
      @(negedge clk);
      mask = want[0] ? 16'h3FFF : 16'hFFFF;
      check_vec(tag, obs & mask, want & mask);
   endtask

   localparam logic [15:0] ZERO = 16'h0000;
   localparam logic [15:0] ILL  = 16'h0001;

   initial begin
      n_vec  = 0;
      n_err  = 0;
      reset  = 1'b1;
      opcode = 7'b0110011;
      funct3 = 3'b000;
      funct7 = 7'b0000000;

      // Reset holds outputs at 0 across edges whatever the inputs are.
      repeat (2) @(negedge clk);
      check_vec("reset_r", obs, ZERO);
      opcode = 7'b1101111;
      @(negedge clk);
      check_vec("reset_jal", obs, ZERO);

      reset = 1'b0;
      run_vec("r_add",     7'b0110011, 3'b000, 7'b0000000, e(2'b10,0,2'b00,3'b000,1,0,0,2'b00,0,0,0));
      run_vec("r_sub",     7'b0110011, 3'b000, 7'b0100000, e(2'b10,0,2'b00,3'b000,1,0,0,2'b00,0,0,0));
      run_vec("r_sra",     7'b0110011, 3'b101, 7'b0100000, e(2'b10,0,2'b00,3'b000,1,0,0,2'b00,0,0,0));
      run_vec("r_sll_alt", 7'b0110011, 3'b001, 7'b0100000, ILL);
      run_vec("r_bad_f7",  7'b0110011, 3'b111, 7'b0000001, ILL);
      run_vec("addi",      7'b0010011, 3'b000, 7'b1111111, e(2'b11,1,2'b00,3'b000,1,0,0,2'b00,0,0,0));
      run_vec("slli_bad",  7'b0010011, 3'b001, 7'b0100000, ILL);
      run_vec("srai",      7'b0010011, 3'b101, 7'b0100000, e(2'b11,1,2'b00,3'b000,1,0,0,2'b00,0,0,0));
      run_vec("srli_bad",  7'b0010011, 3'b101, 7'b0000001, ILL);
      run_vec("lw",        7'b0000011, 3'b010, 7'b0000000, e(2'b00,1,2'b00,3'b000,1,1,0,2'b01,0,0,0));
      run_vec("lhu",       7'b0000011, 3'b101, 7'b0000000, e(2'b00,1,2'b00,3'b000,1,1,0,2'b01,0,0,0));
      run_vec("load_011",  7'b0000011, 3'b011, 7'b0000000, ILL);
      run_vec("sw",        7'b0100011, 3'b010, 7'b0000000, e(2'b00,1,2'b00,3'b001,0,0,1,2'b00,0,0,0));
      run_vec("store_011", 7'b0100011, 3'b011, 7'b0000000, ILL);
      run_vec("bne",       7'b1100011, 3'b001, 7'b0000000, e(2'b01,0,2'b00,3'b010,0,0,0,2'b00,1,0,0));
      run_vec("bgeu",      7'b1100011, 3'b111, 7'b0000000, e(2'b01,0,2'b00,3'b010,0,0,0,2'b00,1,0,0));
      run_vec("br_010",    7'b1100011, 3'b010, 7'b0000000, ILL);
      run_vec("jal",       7'b1101111, 3'b011, 7'b0101010, e(2'b00,1,2'b01,3'b100,1,0,0,2'b10,0,1,0));
      run_vec("jalr",      7'b1100111, 3'b000, 7'b0000000, e(2'b00,1,2'b00,3'b000,1,0,0,2'b10,0,1,0));
      run_vec("jalr_001",  7'b1100111, 3'b001, 7'b0000000, ILL);
      run_vec("lui",       7'b0110111, 3'b110, 7'b1000000, e(2'b00,1,2'b10,3'b011,1,0,0,2'b00,0,0,0));
      run_vec("auipc",     7'b0010111, 3'b000, 7'b0000000, e(2'b00,1,2'b01,3'b011,1,0,0,2'b00,0,0,0));
      run_vec("system",    7'b1110011, 3'b000, 7'b0000000, ILL);
      run_vec("op_7f",     7'b1111111, 3'b000, 7'b0000000, ILL);

      // Mid-cycle reset: must clear without a clock edge.
      #2 reset = 1'b1;
      #1 check_vec("async_clr", obs, ZERO);
      @(negedge clk);
      check_vec("reset_hold", obs, ZERO);
      reset = 1'b0;
      #1 check_vec("post_rel", obs, ZERO);
      @(negedge clk);
      check_vec("first_dec", obs, ILL);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
